// File: rtl/seg7_scan_driver.sv
// Multiplexed hex seven-segment scanner with frame-synchronous shadow value,
// leading-zero blanking and per-slot dead time. Define SEG7_PWM_EN for brightness PWM.
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_CYCLES = 100000,
    parameter int CW             = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    input  logic [3:0]            brightness,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int            IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(REFRESH_CYCLES - 1);

    logic [CW-1:0]       r_slot_cnt;
    logic [IW-1:0]       r_idx;
    logic [4*DIGITS-1:0] r_shadow;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_an;
    logic                r_frame_done;

    logic                w_wrap;
    logic                w_frame;
    logic                w_lit;
    logic                w_zero_run;
    logic                w_blank_sel;
    logic [3:0]          w_digit;
    logic [DIGITS-1:0]   w_blank;
    logic [6:0]          w_seg_nxt;
    logic [DIGITS-1:0]   w_an_nxt;
    logic                w_pwm_on;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'h0:    f_decode = 7'b0000001;
            4'h1:    f_decode = 7'b1001111;
            4'h2:    f_decode = 7'b0010010;
            4'h3:    f_decode = 7'b0000110;
            4'h4:    f_decode = 7'b1001100;
            4'h5:    f_decode = 7'b0100100;
            4'h6:    f_decode = 7'b0100000;
            4'h7:    f_decode = 7'b0001111;
            4'h8:    f_decode = 7'b0000000;
            4'h9:    f_decode = 7'b0000100;
            4'hA:    f_decode = 7'b0001000;
            4'hB:    f_decode = 7'b1100000;
            4'hC:    f_decode = 7'b0110001;
            4'hD:    f_decode = 7'b1000010;
            4'hE:    f_decode = 7'b0110000;
            default: f_decode = 7'b0111000;
        endcase
    endfunction

    assign w_wrap  = (r_slot_cnt == LAST_SLOT);
    assign w_frame = w_wrap && (r_idx == LAST_IDX);

`ifdef SEG7_PWM_EN
    logic [3:0] r_pwm_ph;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_ph <= '0;
        end else begin
            r_pwm_ph <= r_pwm_ph + 4'd1;
        end
    end

    assign w_pwm_on = (r_pwm_ph < brightness);
`else
    logic w_unused_brightness;

    assign w_unused_brightness = ^brightness;
    assign w_pwm_on            = 1'b1;
`endif

    // Blank mask is built from the top digit down; the running AND tracks "all higher digits zero".
    always_comb begin
        w_zero_run  = 1'b1;
        w_blank     = '0;
        w_digit     = 4'h0;
        w_blank_sel = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            w_zero_run = w_zero_run & (r_shadow[4*(DIGITS-1-k) +: 4] == 4'h0);
            w_blank[DIGITS-1-k] = blank_lz & w_zero_run & (k != DIGITS - 1);
        end
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_digit     = r_shadow[4*k +: 4];
                w_blank_sel = w_blank[k];
            end
        end
    end

    always_comb begin
        w_lit     = (r_slot_cnt != '0) && !w_blank_sel && w_pwm_on;
        w_seg_nxt = w_lit ? f_decode(w_digit) : 7'h7F;
        w_an_nxt  = '1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            w_an_nxt[k] = ~(w_lit && (r_idx == IW'(k)));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_cnt   <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_seg        <= 7'h7F;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_slot_cnt <= w_wrap ? '0 : r_slot_cnt + CW'(1);
            if (w_wrap) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
            end
            if (w_frame) begin
                r_shadow <= value;
            end
            r_frame_done <= w_frame;
            r_seg        <= w_seg_nxt;
            r_an         <= w_an_nxt;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4-digit, 3-digit and 1-digit instances.
module tb_seg7_scan_driver;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic [15:0] value4;
    logic        blz4;
    logic [3:0]  bright4;
    logic [6:0]  seg4;
    logic [3:0]  an4;
    logic        fd4;

    logic [11:0] value3;
    logic        blz3;
    logic [6:0]  seg3;
    logic [2:0]  an3;
    logic        fd3;

    logic [3:0]  value_p;
    logic        blz_p;
    logic [3:0]  bright_p;
    logic [6:0]  seg_p;
    logic [0:0]  an_p;
    logic        fd_p;

    int checks   = 0;
    int failures = 0;
    int an_bad   = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .REFRESH_CYCLES(4), .CW(2)) u_dut4 (
        .clk(clk), .reset(reset), .value(value4), .blank_lz(blz4), .brightness(bright4),
        .seg(seg4), .an(an4), .frame_done(fd4)
    );

    seg7_scan_driver #(.DIGITS(3), .REFRESH_CYCLES(5), .CW(3)) u_dut3 (
        .clk(clk), .reset(reset), .value(value3), .blank_lz(blz3), .brightness(bright4),
        .seg(seg3), .an(an3), .frame_done(fd3)
    );

    seg7_scan_driver #(.DIGITS(1), .REFRESH_CYCLES(40), .CW(6)) u_dutp (
        .clk(clk), .reset(reset), .value(value_p), .blank_lz(blz_p), .brightness(bright_p),
        .seg(seg_p), .an(an_p), .frame_done(fd_p)
    );

    typedef struct packed {
        logic [15:0]     value;
        logic            blz;
        logic [3:0][3:0] an;   // {digit3, digit2, digit1, digit0}
        logic [3:0][6:0] seg;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_fd(input int sel);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            tick();
            case (sel)
                4:       seen = fd4;
                3:       seen = fd3;
                default: seen = fd_p;
            endcase
        end
        if (!seen) chk($sformatf("frame_done_timeout_%0d", sel), 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (!(an3 inside {3'h6, 3'h5, 3'h3, 3'h7})) an_bad++;
            if (!(an4 inside {4'hE, 4'hD, 4'hB, 4'h7, 4'hF})) an_bad++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [3:0][6:0] old_seg;
        logic [3:0][2:0] an3_exp;
        logic [3:0][6:0] seg3_exp;
        int fd3_extra;
        int lit_cnt;

        vecs[0] = '{16'h18F0, 1'b0, {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'b1001111, 7'b0000000, 7'b0111000, 7'b0000001}};
        vecs[1] = '{16'h1234, 1'b0, {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
        vecs[2] = '{16'h0050, 1'b1, {4'hF, 4'hF, 4'hD, 4'hE},
                    {7'h7F, 7'h7F, 7'b0100100, 7'b0000001}};
        vecs[3] = '{16'h0000, 1'b1, {4'hF, 4'hF, 4'hF, 4'hE},
                    {7'h7F, 7'h7F, 7'h7F, 7'b0000001}};
        vecs[4] = '{16'hABCD, 1'b0, {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010}};
        vecs[5] = '{16'h0E60, 1'b1, {4'hF, 4'hB, 4'hD, 4'hE},
                    {7'h7F, 7'b0110000, 7'b0100000, 7'b0000001}};
        vecs[6] = '{16'h7095, 1'b1, {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'b0001111, 7'b0000001, 7'b0000100, 7'b0100100}};
        vecs[7] = '{16'h0050, 1'b0, {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001}};

        value4   = 16'h0000;
        blz4     = 1'b0;
        bright4  = 4'hF;
        value3   = 12'h321;
        blz3     = 1'b0;
        value_p  = 4'h8;
        blz_p    = 1'b0;
        bright_p = 4'h4;

        repeat (3) tick();
        chk("rst_an4", 32'(an4), 32'hF);
        chk("rst_seg4", 32'(seg4), 32'h7F);
        chk("rst_fd4", 32'(fd4), 32'h0);
        chk("rst_an3", 32'(an3), 32'h7);
        reset = 1'b0;
        tick();
        chk("post_rst_dark_an4", 32'(an4), 32'hF);
        tick();
`ifndef SEG7_PWM_EN
        chk("first_lit_an4", 32'(an4), 32'hE);
        chk("first_lit_seg4", 32'(seg4), 32'b0000001);

        // Frame after the boundary that loaded the vector: dark then three lit cycles per slot.
        for (int i = 0; i < 8; i++) begin
            value4 = vecs[i].value;
            blz4   = vecs[i].blz;
            wait_fd(4);
            for (int d = 0; d < 4; d++) begin
                tick();
                chk($sformatf("vec%0d_d%0d_dark_an", i, d), 32'(an4), 32'hF);
                chk($sformatf("vec%0d_d%0d_dark_seg", i, d), 32'(seg4), 32'h7F);
                tick();
                chk($sformatf("vec%0d_d%0d_an", i, d), 32'(an4), 32'(vecs[i].an[d]));
                chk($sformatf("vec%0d_d%0d_seg", i, d), 32'(seg4), 32'(vecs[i].seg[d]));
                tick();
                tick();
            end
        end

        // Mid-frame value change must not tear the current frame.
        old_seg = {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
        value4  = 16'h1234;
        blz4    = 1'b0;
        wait_fd(4);
        tick();
        tick();
        chk("tear_d0_seg", 32'(seg4), 32'(old_seg[0]));
        value4 = 16'hABCD;
        tick();
        tick();
        chk("tear_fd_mid", 32'(fd4), 32'h0);
        for (int d = 1; d < 4; d++) begin
            tick();
            tick();
            chk($sformatf("tear_d%0d_seg", d), 32'(seg4), 32'(old_seg[d]));
            tick();
            tick();
        end
        chk("tear_fd_pulse", 32'(fd4), 32'h1);
        tick();
        chk("tear_fd_one_cycle", 32'(fd4), 32'h0);
        tick();
        chk("tear_new_an", 32'(an4), 32'hE);
        chk("tear_new_seg", 32'(seg4), 32'b1000010);

        // blank_lz takes effect without waiting for a frame boundary.
        value4 = 16'h0050;
        blz4   = 1'b1;
        wait_fd(4);
        blz4 = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 10) begin
                chk("blz_live_d2_an", 32'(an4), 32'hB);
                chk("blz_live_d2_seg", 32'(seg4), 32'b0000001);
            end
            if (k == 14) begin
                chk("blz_live_d3_an", 32'(an4), 32'h7);
                chk("blz_live_d3_seg", 32'(seg4), 32'b0000001);
            end
        end

        // Three-digit instance: 5-cycle slots, 15-cycle frames.
        an3_exp  = {3'h6, 3'h3, 3'h5, 3'h6};
        seg3_exp = {7'b1001111, 7'b0000110, 7'b0010010, 7'b1001111};
        fd3_extra = 0;
        wait_fd(3);
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 1) chk("d3_dark_an", 32'(an3), 32'h7);
            if (k == 2 || k == 7 || k == 12 || k == 17) begin
                chk($sformatf("d3_k%0d_an", k), 32'(an3), 32'(an3_exp[(k-2)/5]));
                chk($sformatf("d3_k%0d_seg", k), 32'(seg3), 32'(seg3_exp[(k-2)/5]));
            end
            if (k < 15 && fd3) fd3_extra++;
            if (k == 15) chk("d3_fd_period", 32'(fd3), 32'h1);
        end
        chk("d3_fd_extra", 32'(fd3_extra), 32'h0);
`endif

        // Asynchronous reset while outputs are lit and frame_done is high.
        value4 = 16'h1234;
        blz4   = 1'b0;
        wait_fd(4);
        chk("pre_rst_fd4", 32'(fd4), 32'h1);
        value4 = 16'h5678;
        reset  = 1'b1;
        #1;
        chk("async_rst_an4", 32'(an4), 32'hF);
        chk("async_rst_seg4", 32'(seg4), 32'h7F);
        chk("async_rst_fd4", 32'(fd4), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rerst_dark_an4", 32'(an4), 32'hF);
        tick();
`ifndef SEG7_PWM_EN
        chk("rerst_lit_an4", 32'(an4), 32'hE);
        chk("rerst_lit_seg4", 32'(seg4), 32'b0000001);
`endif

        // Single-digit instance: every slot wrap is a frame boundary.
        wait_fd(1);
        tick();
        chk("p_dark_an", 32'(an_p), 32'h1);
        lit_cnt = 0;
        repeat (16) begin
            tick();
            if (an_p == 1'b0) lit_cnt++;
        end
`ifdef SEG7_PWM_EN
        chk("p_duty_b4", 32'(lit_cnt), 32'd4);
`else
        chk("p_duty_b4", 32'(lit_cnt), 32'd16);
        chk("p_seg", 32'(seg_p), 32'b0000000);
`endif
        bright_p = 4'h0;
        lit_cnt  = 0;
        repeat (16) begin
            tick();
            if (an_p == 1'b0) lit_cnt++;
        end
`ifdef SEG7_PWM_EN
        chk("p_duty_b0", 32'(lit_cnt), 32'd0);
`else
        chk("p_duty_b0", 32'(lit_cnt), 32'd16);
`endif
        repeat (7) tick();
        chk("p_fd_period", 32'(fd_p), 32'h1);

        chk("an_legal", 32'(an_bad), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
